// File: rtl/ls_7404_if.sv
// ls_7404_if: inverter channel bundle with registered observation outputs
interface ls_7404_if;
  logic [5:0]  a;
  logic [5:0]  y;
  logic [5:0]  y_q;
  logic [5:0]  y_chg;
  logic [15:0] tcount;
  modport master (output a, input y, y_q, y_chg, tcount);
  modport slave (input a, output y, y_q, y_chg, tcount);
endinterface

// File: rtl/ls_7404.sv
// ls_7404: hex inverter with clocked shadow register, edge flags and transition counter
module ls_7404 (
  input logic     clk,
  input logic     rst,
  ls_7404_if.slave bus
);
  logic [5:0]  inv;
  logic [5:0]  diff;
  logic [5:0]  y_q;
  logic [5:0]  y_chg;
  logic [15:0] tcount;
  // Kept free of clk/rst so the gates work with those pins floating
  assign inv = ~bus.a;
  assign bus.y = inv;
  assign diff = y_q ^ inv;
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= 6'h3f;
      y_chg <= 6'h00;
      tcount <= 16'h0000;
    end else begin
      y_q <= inv;
      y_chg <= diff;
      tcount <= (|diff && tcount != 16'hffff) ? tcount + 16'd1 : tcount;
    end
  end
  assign bus.y_q = y_q;
  assign bus.y_chg = y_chg;
  assign bus.tcount = tcount;
endmodule

// File: tb/tb_ls_7404.sv
// tb_ls_7404: randomized check of ls_7404 against a behavioural reference model
module tb_ls_7404;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  int checks = 0;
  int failures = 0;
  int m_cnt;
  logic [5:0] m_yq, m_chg;
  ls_7404_if bus ();
  ls_7404 dut (.clk(clk), .rst(rst), .bus(bus.slave));
  initial begin
    wait (run);
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [5:0] av, input logic r, input bit full);
    int out_prev, out_new, changed;
    bus.a = av;
    rst = r;
    out_prev = m_yq;
    out_new = 63 - av;
    changed = 0;
    for (int i = 0; i < 6; i++)
      if (((out_prev >> i) & 1) != ((out_new >> i) & 1)) changed++;
    if (r) begin
      m_yq = 6'h3f;
      m_chg = 0;
      m_cnt = 0;
    end else begin
      m_chg = 6'(out_prev ^ out_new);
      m_yq = 6'(out_new);
      if (changed > 0 && m_cnt < 65535) m_cnt = m_cnt + 1;
    end
    @(posedge clk);
    #1;
    if (full) begin
      chk("y", 16'(bus.y), 16'(63 - av));
      chk("y_q", 16'(bus.y_q), 16'(m_yq));
      chk("y_chg", 16'(bus.y_chg), 16'(m_chg));
      chk("tcount", bus.tcount, 16'(m_cnt));
    end
  endtask
  initial begin
    m_yq = 6'h3f;
    m_chg = 0;
    m_cnt = 0;
    bus.a = 6'b001010;
    #10 chk("noclk_a0a", 16'(bus.y), 16'h35);
    bus.a = 6'b000101;
    #10 chk("noclk_a05", 16'(bus.y), 16'h3a);
    bus.a = 4'b1010;
    #1 chk("zext", 16'(bus.y), 16'h35);
    for (int v = 0; v < 64; v++) begin
      bus.a = 6'(v);
      #1 chk("comb", 16'(bus.y), 16'(63 - v));
    end
    bus.a = 6'h3f;
    #1 chk("comb_3f", 16'(bus.y), 16'h00);
    run = 1'b1;
    step(6'b101010, 1'b1, 1'b1);
    step(6'b101010, 1'b1, 1'b1);
    chk("rst_y_q", 16'(bus.y_q), 16'h3f);
    chk("rst_tcount", bus.tcount, 16'h0);
    step(6'h00, 1'b0, 1'b1);
    chk("rel_chg", 16'(bus.y_chg), 16'h0);
    step(6'b000011, 1'b0, 1'b1);
    chk("edge_y_q", 16'(bus.y_q), 16'h3c);
    chk("edge_chg", 16'(bus.y_chg), 16'h03);
    chk("edge_cnt", bus.tcount, 16'h1);
    step(6'b000011, 1'b0, 1'b1);
    chk("hold_chg", 16'(bus.y_chg), 16'h0);
    chk("hold_cnt", bus.tcount, 16'h1);
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] av;
      av = ($urandom_range(0, 3) == 0) ? bus.a : 6'($urandom);
      step(av, $urandom_range(0, 99) == 0, 1'b1);
    end
    step(6'h00, 1'b1, 1'b1);
    for (int n = 0; n < 70000; n++) step((n % 2 == 0) ? 6'h3f : 6'h00, 1'b0, n % 4096 == 0);
    chk("sat", bus.tcount, 16'hffff);
    step(6'h3f, 1'b0, 1'b1);
    step(6'h00, 1'b0, 1'b1);
    chk("sat_hold", bus.tcount, 16'hffff);
    bus.a = 6'b010110;
    #1 chk("sat_comb", 16'(bus.y), 16'h29);
    step(6'h15, 1'b1, 1'b1);
    chk("sat_rst", bus.tcount, 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
